// File: rtl/exp_prec_arb.sv
// Round-robin arbiter sharing one precision-expansion stage among NREQ requesters.
// Define EXP_PREC_ARB_SKID_EN for a 2-entry output skid FIFO instead of a single output register.
module exp_prec_arb #(
    parameter int DTYPE  = 1,       // 0 BOOL, 1 INT, 2 FXP, 3 FP
    parameter bit SIGNED = 1'b1,
    parameter int I_PREC = 8,
    parameter int I_FRAC = 0,
    parameter int O_PREC = 16,
    parameter int O_FRAC = 0,
    parameter int NREQ   = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*I_PREC-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   out_valid,
    output logic [O_PREC-1:0]      out_data,
    output logic [IDW-1:0]         out_id,
    input  logic                   out_ready
);
    localparam int DT_BOOL = 0;
    localparam int DT_FXP  = 2;
    localparam int DT_FP   = 3;
    localparam int FSHIFT  = (DTYPE == DT_FXP) ? (O_FRAC - I_FRAC) : 0;

    if (DTYPE == DT_FP) begin : g_fp_unsupported
        $error("exp_prec_arb: FP dtype is not supported");
    end else if ((FSHIFT < 0) || (O_PREC - FSHIFT < I_PREC)) begin : g_bad_widths
        $error("exp_prec_arb: output format cannot hold the input format");
    end

    // Sign/zero extension followed by fraction-point alignment.
    function automatic logic [O_PREC-1:0] widen(input logic [I_PREC-1:0] x);
        logic [O_PREC-1:0] ext_v;
        if (SIGNED && (DTYPE != DT_BOOL)) begin
            ext_v = O_PREC'($signed(x));
        end else begin
            ext_v = O_PREC'(x);
        end
        return ext_v << FSHIFT;
    endfunction

    logic [I_PREC-1:0] slice_s [NREQ];
    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign slice_s[g] = req_data[g*I_PREC +: I_PREC];
    end

    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic              gnt_found_s;
    logic [IDW-1:0]    gnt_idx_s;
    logic              can_accept_s;
    logic              push_s;
    logic [O_PREC-1:0] gnt_word_s;

    // Search for the first valid requester starting at the round-robin pointer.
    always_comb begin
        int cand_v;
        cand_v      = 0;
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_v = (int'(rr_ptr_q) + k) % NREQ;
            if (!gnt_found_s && req_valid[cand_v[IDW-1:0]]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = cand_v[IDW-1:0];
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    assign push_s     = gnt_found_s & can_accept_s;
    assign gnt_word_s = widen(slice_s[gnt_idx_s]);

    // One-hot grant and pointer advance past the served requester.
    always_comb begin
        if (push_s) begin
            req_ready = NREQ'(1'b1) << gnt_idx_s;
            rr_ptr_d  = (gnt_idx_s == IDW'(NREQ - 1)) ? '0 : gnt_idx_s + 1'b1;
        end else begin
            req_ready = '0;
            rr_ptr_d  = rr_ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef EXP_PREC_ARB_SKID_EN
    logic [O_PREC-1:0] mem_data_q [2];
    logic [O_PREC-1:0] mem_data_d [2];
    logic [IDW-1:0]    mem_id_q [2];
    logic [IDW-1:0]    mem_id_d [2];
    logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              pop_s;

    // Acceptance depends only on registered occupancy, cutting the out_ready path.
    assign can_accept_s = (count_q != 2'd2);
    assign pop_s        = (count_q != 2'd0) & out_ready;

    // FIFO next-state: write at tail, read from head, track occupancy.
    always_comb begin
        mem_data_d = mem_data_q;
        mem_id_d   = mem_id_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push_s) begin
            mem_data_d[wr_ptr_q] = gnt_word_s;
            mem_id_d[wr_ptr_q]   = gnt_idx_s;
            wr_ptr_d             = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int e = 0; e < 2; e++) begin
                mem_data_q[e] <= '0;
                mem_id_q[e]   <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_data_q <= mem_data_d;
            mem_id_q   <= mem_id_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_data_q[rd_ptr_q];
    assign out_id    = mem_id_q[rd_ptr_q];
`else
    logic              out_valid_q, out_valid_d;
    logic [O_PREC-1:0] out_data_q, out_data_d;
    logic [IDW-1:0]    out_id_q, out_id_d;

    assign can_accept_s = ~out_valid_q | out_ready;

    // Output register: reload on grant, clear valid on a pop with no refill.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        if (push_s) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_word_s;
            out_id_d    = gnt_idx_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register state.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
`endif

endmodule

// File: tb/tb_exp_prec_arb.sv
// Randomized scoreboard bench for exp_prec_arb (INT signed 8b -> 16b, NREQ=4), with or without EXP_PREC_ARB_SKID_EN.
module tb_exp_prec_arb;
    localparam int NREQ = 4;
`ifdef EXP_PREC_ARB_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_id;
    logic        out_ready;

    exp_prec_arb #(
        .DTYPE(1), .SIGNED(1'b1), .I_PREC(8), .I_FRAC(0),
        .O_PREC(16), .O_FRAC(0), .NREQ(NREQ)
    ) dut (
        .clk(clk), .reset_(reset_),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] data;
    } item_t;

    item_t sb[$];
    int    errors = 0;
    int    checks = 0;
    int    rr_m = 0;
    int    this_push = 0;
    bit    in_rst = 1'b1;
    int    gcnt [NREQ];
    int    wcnt [NREQ];

    function automatic logic [15:0] widen_m(input logic [7:0] d);
        int v;
        v = int'(d);
        if (v >= 128) v = v - 256;
        return 16'(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; the model predicts the grant and queues the expected output.
    task automatic step(input logic [3:0] v, input logic [31:0] d, input logic r);
        int occ;
        int g;
        bit acc;
        logic [3:0] exp_rdy;
        @(negedge clk);
        req_valid = v;
        req_data  = d;
        out_ready = r;
        #2;
        occ = sb.size();
        acc = (CAP == 2) ? (occ < 2) : ((occ == 0) || r);
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && v[(rr_m + k) % NREQ]) g = (rr_m + k) % NREQ;
        end
        exp_rdy = (acc && g >= 0) ? 4'(1 << g) : 4'b0000;
        check("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
        this_push = 0;
        if (exp_rdy != 4'b0000) begin
            sb.push_back('{id: 2'(g), data: widen_m(d[g*8 +: 8])});
            rr_m = (g + 1) % NREQ;
            this_push = 1;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                gcnt[i]++;
                check("fairness", wcnt[i] < NREQ, 1);
                wcnt[i] = 0;
            end else if (v[i] && req_ready != 4'b0000) begin
                wcnt[i]++;
            end else if (!v[i]) begin
                wcnt[i] = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = 4'b0000;
        out_ready = 1'b0;
        #1;
        reset_ = 1'b0;
        in_rst = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'h0000);
        check("rst_out_id", {30'd0, out_id}, 32'd0);
        sb.delete();
        rr_m = 0;
        this_push = 0;
        for (int i = 0; i < NREQ; i++) wcnt[i] = 0;
        repeat (2) @(negedge clk);
        #1;
        reset_ = 1'b1;
        in_rst = 1'b0;
    endtask

    // Monitor: compares the presented word with the scoreboard head and pops on each handshake.
    initial begin
        item_t it;
        int    pend;
        forever begin
            @(negedge clk);
            #3;
            if (!in_rst) begin
                pend = sb.size() - this_push;
                check("out_valid", {31'd0, out_valid}, {31'd0, pend > 0});
                if (out_valid && pend > 0) begin
                    check("out_data", {16'd0, out_data}, {16'd0, sb[0].data});
                    check("out_id", {30'd0, out_id}, {30'd0, sb[0].id});
                    if (out_ready) it = sb.pop_front();
                end
            end
        end
    end

    initial begin
        int tot;
        reset_    = 1'b0;
        req_valid = 4'b0000;
        req_data  = 32'd0;
        out_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            gcnt[i] = 0;
            wcnt[i] = 0;
        end
        do_reset();

        // All requesting with a free output: strict rotation, two grants each.
        for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
        repeat (8) step(4'b1111, $urandom, 1'b1);
        for (int i = 0; i < NREQ; i++) check("rotation_grants", gcnt[i], 2);
        repeat (3) step(4'b0000, $urandom, 1'b1);

        // Sign extension of the extreme values.
        step(4'b0100, 32'h0080_0000, 1'b1);
        step(4'b0000, 32'd0, 1'b1);
        check("neg_ext_data", {16'd0, out_data}, 32'h0000_FF80);
        check("neg_ext_id", {30'd0, out_id}, 32'd2);
        step(4'b0100, 32'h007F_0000, 1'b1);
        step(4'b0000, 32'd0, 1'b1);
        check("pos_ext_data", {16'd0, out_data}, 32'h0000_007F);
        repeat (2) step(4'b0000, 32'd0, 1'b1);

        // Back-pressure with everyone requesting.
        step(4'b0001, $urandom, 1'b1);
        for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
        repeat (5) step(4'b1111, $urandom, 1'b0);
        tot = gcnt[0] + gcnt[1] + gcnt[2] + gcnt[3];
        check("stall_grants", tot, CAP - 1);
        repeat (4) step(4'b0000, $urandom, 1'b1);

        // Pointer wrap: serve req 2, then 3, then 0, then 1 is next.
        step(4'b0100, $urandom, 1'b1);
        step(4'b1001, $urandom, 1'b1);
        check("wrap_grant3", {28'd0, req_ready}, 32'b1000);
        step(4'b1001, $urandom, 1'b1);
        check("wrap_grant0", {28'd0, req_ready}, 32'b0001);
        step(4'b1111, $urandom, 1'b1);
        check("wrap_grant1", {28'd0, req_ready}, 32'b0010);

        // Reset while data is buffered, then the first grant goes to req 0.
        repeat (3) step(4'b1111, $urandom, 1'b0);
        do_reset();
        step(4'b1111, $urandom, 1'b1);
        check("first_grant", {28'd0, req_ready}, 32'b0001);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            step(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 9) < 7));
        end
        repeat (6) step(4'b0000, $urandom, 1'b1);
        check("drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
